ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 4: RAM word and stream data width.
REQ-002 Parameter ADDR_WIDTH, default 8: RAM address width.
REQ-003 Parameter RD_LATENCY, default 2: RAM read latency in cycles; legal values are 1 (unregistered read data) and 2 (registered read data); any other value SHALL cause $fatal at elaboration.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port go, input, 1: start a transfer; sampled only in IDLE.
REQ-008 Port start_addr, input, ADDR_WIDTH: first word address; sampled when go is accepted.
REQ-009 Port size, input, ADDR_WIDTH+1: word count, 0..2**ADDR_WIDTH; sampled when go is accepted.
REQ-010 Port done, output, 1: transfer complete (level signal).
REQ-011 Port ram_en, output, 1: RAM port enable; the RAM port write enable is tied low outside this block.
REQ-012 Port ram_addr, output, ADDR_WIDTH: RAM read address.
REQ-013 Port ram_rd_data, input, DATA_WIDTH: RAM read data, valid RD_LATENCY cycles after an enabled read.
REQ-014 Port out_valid, output, 1: stream data valid.
REQ-015 Port out_ready, input, 1: stream consumer ready.
REQ-016 Port out_data, output, DATA_WIDTH: stream data.

Function
REQ-017 FSM states: IDLE, READ, DRAIN.
- IDLE->READ on go with size>0.
- IDLE stays in IDLE on go with size=0 and sets done the next cycle.
- READ->DRAIN the cycle the last address issues.
- DRAIN->IDLE when no read is in flight and the FIFO is empty.
REQ-018 Accepting go SHALL clear done; done SHALL set on the same edge that returns the FSM to IDLE and hold until the next accepted go.
REQ-019 go in READ or DRAIN SHALL be ignored.
REQ-020 ram_en SHALL be 1 continuously in READ and DRAIN and 0 in IDLE; this keeps the RAM output register advancing.
REQ-021 A read "issues" in a READ cycle when in_flight + fifo_count < FIFO_DEPTH.
- FIFO_DEPTH is fixed at RD_LATENCY+2.
- ram_addr SHALL advance by 1 only on an issue cycle.
- On non-issue cycles ram_addr SHALL hold and the returned data SHALL be discarded.
REQ-022 An RD_LATENCY-deep valid shift register SHALL tag issued reads; a tagged ram_rd_data SHALL be written into the FIFO exactly RD_LATENCY cycles after issue.
REQ-023 ram_addr SHALL wrap modulo 2**ADDR_WIDTH (255 -> 0 at ADDR_WIDTH=8).
REQ-024 Exactly size words SHALL be issued, in address order.
REQ-025 The stream interface SHALL follow valid/ready rules.
- A transfer occurs when out_valid and out_ready are both 1.
- out_valid and out_data SHALL remain stable while out_valid=1 and out_ready=0.
- out_valid SHALL drop only after a transfer leaves the FIFO empty.
REQ-026 FIFO write and read in the same cycle SHALL leave the count unchanged; the FIFO SHALL never overflow, which REQ-021 guarantees.
REQ-027 With out_ready held at 1, sustained throughput SHALL be 1 word per cycle; the first out_valid SHALL occur RD_LATENCY+1 cycles after the go edge.

Reset
REQ-028 On rst_n=0 the block SHALL asynchronously enter IDLE and empty the FIFO and the valid shift register.
REQ-029 On rst_n=0: done=0, out_valid=0, ram_en=0, ram_addr=0, out_data=0.
REQ-030 Reset mid-transfer SHALL abort the transfer; no words from it SHALL appear on the stream after rst_n rises.

Verification
REQ-031 Basic run, RD_LATENCY=2, RAM[i]=i, start_addr=4, size=5, out_ready=1 -> out_data 4,5,6,7,8 on consecutive cycles; done=1 after the last transfer.
REQ-032 Wrap-around, ADDR_WIDTH=8, start_addr=254, size=4 -> ram_addr sequence 254,255,0,1; stream 254,255,0,1.
REQ-033 Backpressure: out_ready=0 for 10 cycles after go, size=8 -> at most FIFO_DEPTH reads issue and out_data stays stable; after out_ready=1, all 8 words arrive in order with no loss or duplicates.
REQ-034 Edge sizes:
- size=0 -> done=1 one cycle after go; out_valid never asserts.
- size=256 -> 256 words stream, then done=1.
REQ-035 Busy go and reset:
- go pulsed in READ -> ignored; the transfer completes unchanged.
- rst_n low mid-DRAIN -> all outputs at REQ-029 values immediately.
REQ-036 Repeat both RD_LATENCY=1 and RD_LATENCY=2 with random out_ready; a scoreboard SHALL confirm the data order.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams size words from a synchronous-read RAM onto a valid/ready port, starting at start_addr.
// Small FIFO plus an in-flight valid tag pipe lets reads stall under backpressure without losing RAM data.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   size,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $fatal(1, "ram_stream_reader: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  done_q, done_d;
  logic [RD_LATENCY-1:0] vsr_q, vsr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         in_flight;
  logic                  issue;
  logic                  fifo_wr;
  logic                  fifo_rd;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CW'(vsr_q[i]);
    end
  end

  // Reserve a FIFO slot for every read in flight so returned data always has a home.
  assign issue   = (state_q == READ) &&
                   (({1'b0, in_flight} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH));
  assign vsr_d   = (vsr_q << 1) | RD_LATENCY'(issue);
  assign fifo_wr = vsr_q[RD_LATENCY-1];
  assign fifo_rd = out_valid && out_ready;

  assign ram_en    = (state_q != IDLE);
  assign ram_addr  = addr_q;
  assign done      = done_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          addr_d = start_addr;
          rem_d  = size;
          if (size == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - (ADDR_WIDTH + 1)'(1);
          if (rem_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (in_flight == '0 && count_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      vsr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      vsr_q   <= vsr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) begin
        mem_q[wr_ptr_q] <= ram_rd_data;
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (fifo_rd) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
